// File: rtl/neuron_pkg.sv
// Shared parameters and helpers for the neuron MAC datapath.
// Holds default sizes, accumulator width derivation and saturation.
package neuron_pkg;

    localparam int N_DEF    = 8;
    localparam int D_DEF    = 4;
    localparam int Q_DEF    = 4;
    localparam int FRAC_DEF = 4;

    // Wide enough for D full-scale products plus a sign guard bit.
    function automatic int acc_width(input int n, input int d);
        return 2 * n + $clog2(d) + 1;
    endfunction

    // Clamp a signed value to the n-bit two's complement range.
    function automatic longint sat_val(input longint v, input int n);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (n - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO with arbitrary depth.
// Push while full is dropped unless a pop frees a slot that cycle.
module result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop_ready,
    output logic                       valid,
    output logic [W-1:0]               data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;
    logic             do_push;

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign data    = valid ? mem[rd_ptr] : '0;
    assign count   = cnt_q;
    assign pop     = valid & pop_ready;
    assign do_push = push & (~full | pop);

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            cnt_q        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(pop);
            if (push & full & ~pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/neuron_mac_datapath.sv
// Signed fixed-point multiply-accumulate neuron with result FIFO.
// Optional ReLU on pushed results via NEURON_RELU_EN.
module neuron_mac_datapath
    import neuron_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int D    = D_DEF,
    parameter int Q    = Q_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           x_in,
    input  logic [N-1:0]           w_in,
    input  logic                   write_x,
    input  logic                   write_w,
    input  logic                   acc_write,
    input  logic                   clear_acc,
    input  logic                   res_write,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N-1:0]           res_data,
    output logic [$clog2(Q+1)-1:0] res_count,
    output logic                   fifo_full,
    output logic                   overflow_err
);

    localparam int ACC_W = acc_width(N, D);

    logic signed [N-1:0]     x_q;
    logic signed [N-1:0]     w_q;
    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_shr;
    longint                  acc_wide;
    logic [N-1:0]            res_sat;
    logic [N-1:0]            push_data;

    assign prod     = x_q * w_q;
    assign prod_ext = ACC_W'(prod);
    assign acc_shr  = acc_q >>> FRAC;

    // Operand registers and accumulator; clear beats accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            w_q   <= '0;
            acc_q <= '0;
        end else begin
            if (write_x) begin
                x_q <= x_in;
            end
            if (write_w) begin
                w_q <= w_in;
            end
            if (clear_acc) begin
                acc_q <= '0;
            end else if (acc_write) begin
                acc_q <= acc_q + prod_ext;
            end
        end
    end

    // Rescale the pre-update accumulator to an N-bit saturated result.
    always_comb begin
        acc_wide = longint'(acc_shr);
        res_sat  = N'(sat_val(acc_wide, N));
`ifdef NEURON_RELU_EN
        push_data = res_sat[N-1] ? '0 : res_sat;
`else
        push_data = res_sat;
`endif
    end

    result_fifo #(
        .W     (N),
        .DEPTH (Q)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (res_write),
        .push_data    (push_data),
        .pop_ready    (res_ready),
        .valid        (res_valid),
        .data         (res_data),
        .count        (res_count),
        .full         (fifo_full),
        .overflow_err (overflow_err)
    );

endmodule
